// File: rtl/upsampler2x2.sv
// upsampler2x2 -- 2x nearest-neighbour image upsampler.
//
// A WxH frame of 8-bit pixels arrives in raster order and leaves as a 2Wx2H
// frame. Each input pixel is sent twice in a row, and each row is sent twice.
// The first copy of a row is built from the incoming pixels (FILL). As it is
// built, each pixel is also written to a line buffer. The second copy of the
// row is then read back from that buffer (REPLAY).
//
// Handshake (both ports): a word transfers on a rising edge where valid and
// ready are both high. Once out_valid is raised, pixel_out, out_valid and
// out_last hold steady until the word transfers. in_ready may depend
// combinationally on out_ready. The reverse never happens: no output depends
// on an input in that way.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   width      input row length W (0 keeps the block idle)
//   height     input row count H  (0 keeps the block idle)
//   in_valid   pixel_in valid
//   in_ready   block accepts pixel_in this cycle
//   pixel_in   signed input pixel
//   out_valid  pixel_out valid
//   out_ready  downstream accepts pixel_out
//   pixel_out  upsampled pixel (registered)
//   out_last   marks the final pixel of the output frame
//   frame_done one-cycle pulse after the out_last pixel transfers
//   state_dbg  current FSM state (IDLE=0, FILL=1, REPLAY=2), for observation
module upsampler2x2 #(
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] width,
  input  logic [7:0] height,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] pixel_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] pixel_out,
  output logic       out_last,
  output logic       frame_done,
  output logic [1:0] state_dbg
);

  // Column indices fit in 8 bits, so IMAGE_WIDTH is limited to 256.
  localparam int AW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam logic [7:0] W_MAX = 8'((IMAGE_WIDTH  > 255) ? 255 : IMAGE_WIDTH);
  localparam logic [7:0] H_MAX = 8'((IMAGE_HEIGHT > 255) ? 255 : IMAGE_HEIGHT);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, REPLAY = 2'd2} state_t;

  state_t     state, state_nxt;
  logic [7:0] w_lat, h_lat;
  logic [7:0] col, row;
  logic       phase;
  logic [7:0] hold;
  logic [7:0] linebuf [IMAGE_WIDTH];

  logic          adv;       // output register may take a new value
  logic          in_xfer;
  logic          last_col;
  logic          last_row;
  logic          start;
  logic [AW-1:0] col_idx;

  assign col_idx   = col[AW-1:0];
  assign state_dbg = state;

  always_comb begin
    adv       = !out_valid || out_ready;
    last_col  = (col == w_lat - 8'd1);
    last_row  = (row == h_lat - 8'd1);
    // A new frame may start only after the previous final pixel has drained.
    start     = !out_valid && (width != 8'd0) && (height != 8'd0);
    in_ready  = (state == FILL) && !phase && adv;
    in_xfer   = in_valid && in_ready;
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (phase && adv && last_col) state_nxt = REPLAY;
      REPLAY:  if (phase && adv && last_col) state_nxt = last_row ? IDLE : FILL;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Line buffer has no reset; it is always rewritten before it is replayed.
  always_ff @(posedge clk) begin
    if (rst_n && in_xfer) linebuf[col_idx] <= pixel_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_lat      <= 8'd0;
      h_lat      <= 8'd0;
      col        <= 8'd0;
      row        <= 8'd0;
      phase      <= 1'b0;
      hold       <= 8'd0;
      out_valid  <= 1'b0;
      pixel_out  <= 8'd0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          // out_valid can only be high here while the final pixel drains.
          if (out_valid) begin
            if (out_ready) begin
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              frame_done <= 1'b1;
            end
          end else if (start) begin
            w_lat <= (width  > W_MAX) ? W_MAX : width;
            h_lat <= (height > H_MAX) ? H_MAX : height;
            col   <= 8'd0;
            row   <= 8'd0;
            phase <= 1'b0;
          end
        end
        FILL: begin
          if (!phase) begin
            if (in_xfer) begin
              pixel_out <= pixel_in;
              out_valid <= 1'b1;
              hold      <= pixel_in;
              phase     <= 1'b1;
            end else if (adv) begin
              out_valid <= 1'b0;  // bubble while waiting for input
            end
          end else if (adv) begin
            pixel_out <= hold;
            out_valid <= 1'b1;
            phase     <= 1'b0;
            col       <= last_col ? 8'd0 : col + 8'd1;
          end
        end
        REPLAY: begin
          if (adv) begin
            pixel_out <= linebuf[col_idx];
            out_valid <= 1'b1;
            phase     <= !phase;
            if (phase) begin
              col <= last_col ? 8'd0 : col + 8'd1;
              if (last_col) begin
                if (last_row) out_last <= 1'b1;
                else          row      <= row + 8'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_upsampler2x2.sv
// Testbench for upsampler2x2: directed and randomized frames checked against
// a reference model that expands the input pixel list into the upsampled frame.
module tb_upsampler2x2;

  logic       clk;
  logic       rst_n;
  logic [7:0] width;
  logic [7:0] height;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] pixel_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pixel_out;
  logic       out_last;
  logic       frame_done;
  logic [1:0] state_dbg;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] in_q[$];
  logic [7:0] exp_q[$];

  upsampler2x2 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .width      (width),
    .height     (height),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pixel_in   (pixel_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pixel_out  (pixel_out),
    .out_last   (out_last),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: each row appears twice, each pixel twice within a row.
  function automatic void build_expected(input int w, input int h);
    exp_q.delete();
    for (int r = 0; r < h; r++)
      for (int rep = 0; rep < 2; rep++)
        for (int c = 0; c < w; c++) begin
          exp_q.push_back(in_q[r * w + c]);
          exp_q.push_back(in_q[r * w + c]);
        end
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_pixel_out"}, pixel_out, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_in_ready"}, in_ready, 0);
  endtask

  // ---------------- driver / monitor ----------------
  task automatic run_frame(input int w_req, input int h_req, input bit rand_ready,
                           input bit rand_valid, input int abort_at);
    int wc, hc, a, t, bubbles;
    bit seen_valid, prev_stall;
    logic [7:0] prev_px, exp_px;
    logic prev_last;
    wc = (w_req > 128) ? 128 : w_req;
    hc = (h_req > 128) ? 128 : h_req;
    build_expected(wc, hc);
    a = 0; t = 0; bubbles = 0;
    seen_valid = 0; prev_stall = 0; prev_px = 0; prev_last = 0;
    @(negedge clk);
    width  = 8'(w_req);
    height = 8'(h_req);
    for (int cyc = 0; cyc < 40 * wc * hc + 100; cyc++) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (a < in_q.size() && (!rand_valid || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        pixel_in = in_q[a];
      end else begin
        in_valid = 1'b0;
        pixel_in = 8'($urandom);
      end
      #1;
      if (prev_stall) begin
        check("stall_pixel", pixel_out, prev_px);
        check("stall_valid", out_valid, 1);
        check("stall_last", out_last, prev_last);
      end
      check("frame_done_low", frame_done, 0);
      // After a full input row, no input may be taken until its replay drains.
      if (a >= wc * hc || (a > 0 && a % wc == 0 && t < 4 * a - 1))
        check("in_ready_replay", in_ready, 0);
      if (seen_valid && !out_valid) bubbles++;
      if (out_valid) seen_valid = 1;
      if (out_valid && out_ready) begin
        exp_px = exp_q.pop_front();
        check("pixel", pixel_out, exp_px);
        check("last", out_last, exp_q.size() == 0);
        t++;
      end
      if (in_valid && in_ready) begin
        a++;
        if (a == 1) begin
          // Geometry is latched by now; later changes must be ignored.
          width  = 8'($urandom_range(1, 255));
          height = 8'($urandom_range(1, 255));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_px    = pixel_out;
      prev_last  = out_last;
      if (exp_q.size() == 0 || (abort_at > 0 && t == abort_at)) break;
      @(negedge clk);
    end
    if (abort_at > 0) begin
      check("abort_outputs", t, abort_at);
      return;
    end
    check("outputs_remaining", exp_q.size(), 0);
    check("inputs_taken", a, wc * hc);
    if (!rand_ready && !rand_valid) check("no_bubbles", bubbles, 0);
    @(negedge clk);
    width = 8'd0; height = 8'd0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("frame_done_pulse", frame_done, 1);
    check("done_out_valid", out_valid, 0);
    @(negedge clk);
    #1;
    check("frame_done_once", frame_done, 0);
    check("idle_in_ready", in_ready, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; width = 8'd0; height = 8'd0;
    in_valid = 1'b0; pixel_in = 8'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // W=2,H=1 with 5,-3 at full rate
    in_q = '{8'd5, 8'hFD};
    run_frame(2, 1, 0, 0, 0);

    // W=2,H=2 with 1,2,3,4
    in_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    run_frame(2, 2, 0, 0, 0);

    // Same 5,-3 frame under random backpressure, then random input gaps too
    in_q = '{8'd5, 8'hFD};
    run_frame(2, 1, 1, 0, 0);
    run_frame(2, 1, 1, 1, 0);

    // Zero width keeps the block idle
    @(negedge clk);
    width = 8'd0; height = 8'd7; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      check("w0_in_ready", in_ready, 0);
      check("w0_out_valid", out_valid, 0);
      @(negedge clk);
    end
    in_valid = 1'b0; height = 8'd0;

    // Single-column frame at full rate
    in_q.delete();
    for (int i = 0; i < 3; i++) in_q.push_back(8'($urandom));
    run_frame(1, 3, 0, 0, 0);

    // Random geometry and pixels
    for (int k = 0; k < 6; k++) begin
      int w, h;
      w = $urandom_range(1, 9);
      h = $urandom_range(1, 4);
      in_q.delete();
      for (int i = 0; i < w * h; i++) in_q.push_back(8'($urandom));
      run_frame(w, h, 1, 1, 0);
    end

    // Reset after three outputs, then a 1x1 frame of -128
    in_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    run_frame(2, 2, 0, 0, 3);
    @(negedge clk);
    rst_n = 1'b0; width = 8'd0; height = 8'd0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    in_q = '{8'h80};
    run_frame(1, 1, 0, 0, 0);

    // Width beyond IMAGE_WIDTH clamps to 128; extra offered pixels must be refused
    in_q.delete();
    for (int i = 0; i < 200; i++) in_q.push_back(8'($urandom));
    run_frame(200, 1, 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
